// File: rtl/sparc_exu_ecl_divseq.sv
// Divide iteration sequencer for the EXU ECL.
// It accepts a divide start, tests for a zero divisor, and steps through ITERS
// iteration cycles and one fix-up cycle. It then holds a done/ack handshake
// with ECL. The sequencer also drives the reset of the external 6-bit
// iteration counter (sparc_exu_ecl_cnt6) and watches that counter's value.
// Every output is a flop loaded from the next-state decode, so no input has a
// combinational path to any output.
module sparc_exu_ecl_divseq #(
  parameter int ITERS = 32
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       div_start,
  input  logic [1:0] div_thr,
  input  logic       divisor_zero,
  input  logic       div_kill,
  input  logic [5:0] cntr,
  input  logic       div_ack,
  output logic       cnt_reset,
  output logic       div_busy,
  output logic       div_iter_en,
  output logic       div_fix_en,
  output logic       div_done,
  output logic       div_zero_trap,
  output logic [1:0] div_thr_out
);

  // The last RUN cycle is the one in which the counter shows ITERS-1.
  // ITERS=64 gives a terminal count of 63, so the counter never wraps in RUN.
  localparam logic [5:0] TERM_CNT = 6'(ITERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [1:0] thr_r;
  logic [1:0] thr_s;
  logic       zero_r;
  logic       zero_s;

  logic       cnt_reset_r;
  logic       busy_r;
  logic       iter_en_r;
  logic       fix_en_r;
  logic       done_r;
  logic       zero_trap_r;

  // Compute the next state, the captured thread and the zero-divisor flag.
  always_comb begin
    state_s = state_r;
    thr_s   = thr_r;
    zero_s  = zero_r;
    if (div_kill) begin
      // A flush aborts any divide in flight and drops a start issued in IDLE.
      // The thread tag is left unchanged because it is don't-care after a kill.
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_start) begin
            state_s = ST_CHK;
            thr_s   = div_thr;
            zero_s  = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CHK: begin
          if (divisor_zero) begin
            state_s = ST_DONE;
            zero_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cntr == TERM_CNT) begin
            state_s = ST_FIX;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FIX: begin
          state_s = ST_DONE;
        end
        ST_DONE: begin
          if (div_ack) begin
            if (div_start) begin
              // Back-to-back divide: the ack frees the result and the new
              // request goes straight to the divisor check.
              state_s = ST_CHK;
              thr_s   = div_thr;
              zero_s  = 1'b0;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Update the state register, the thread tag and the zero flag; reset wins over all inputs.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_r <= ST_IDLE;
      thr_r   <= 2'd0;
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      thr_r   <= thr_s;
      zero_r  <= zero_s;
    end
  end

  // Load the output flops from the next-state decode so they line up with state_r.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt_reset_r <= 1'b1;
      busy_r      <= 1'b0;
      iter_en_r   <= 1'b0;
      fix_en_r    <= 1'b0;
      done_r      <= 1'b0;
      zero_trap_r <= 1'b0;
    end else begin
      cnt_reset_r <= (state_s != ST_RUN);
      busy_r      <= (state_s != ST_IDLE);
      iter_en_r   <= (state_s == ST_RUN);
      fix_en_r    <= (state_s == ST_FIX);
      done_r      <= (state_s == ST_DONE);
      zero_trap_r <= (state_s == ST_DONE) & zero_s;
    end
  end

  assign cnt_reset     = cnt_reset_r;
  assign div_busy      = busy_r;
  assign div_iter_en   = iter_en_r;
  assign div_fix_en    = fix_en_r;
  assign div_done      = done_r;
  assign div_zero_trap = zero_trap_r;
  assign div_thr_out   = thr_r;

endmodule

// File: doc/sparc_exu_ecl_divseq.md
Name: sparc_exu_ecl_divseq

Overview:
Divide iteration sequencer in EXU ECL. It sits directly downstream of the 6-bit iteration counter (sparc_exu_ecl_cnt6) and consumes its cntr[5:0] output. It also drives that counter's reset. It accepts a divide start from ECL, checks for divide-by-zero, and sequences ITERS iteration cycles, one fix-up cycle and a done/ack handshake back to ECL.

Parameters:
ITERS, 32, number of iteration cycles per divide; legal range 1..64; terminal count is ITERS-1 on the 6-bit counter.

Ports:
clk  input  1  core clock
rst_l  input  1  synchronous active-low reset
div_start  input  1  divide request; one-cycle pulse; accepted only in IDLE (or DONE with ack)
div_thr  input  2  thread id of the request; sampled when the start is accepted
divisor_zero  input  1  divisor is zero; valid in the cycle after an accepted start (CHK state)
div_kill  input  1  flush; aborts any in-flight divide
cntr  input  6  iteration count from sparc_exu_ecl_cnt6
div_ack  input  1  ECL has consumed the result; meaningful only in DONE
cnt_reset  output  1  drives the counter's reset input
div_busy  output  1  divide in flight (any state other than IDLE)
div_iter_en  output  1  datapath iteration enable
div_fix_en  output  1  remainder/overflow fix-up enable
div_done  output  1  result valid; held until ack
div_zero_trap  output  1  done is due to divide-by-zero; qualifies div_done
div_thr_out  output  2  captured thread id; valid while div_busy

Behaviour:
- Interface: one clock, clk. Reset rst_l is synchronous and active-low. All state updates occur on the clk rising edge.
- States: IDLE, CHK, RUN, FIX, DONE. Encoding is free; the state register is one flop bank.
- Reset (rst_l=0 at an edge) puts the block in IDLE, clears div_thr_out to 0 and clears the zero flag to 0. This takes priority over all other inputs, including mid-operation.
- Output values after reset: cnt_reset=1; div_busy, div_iter_en, div_fix_en, div_done, div_zero_trap = 0.
- All outputs decode from registered state and flags only. There is no combinational path from any input to any output.
- Output decode by state:
  - cnt_reset = 1 in every state except RUN.
  - div_iter_en = 1 in RUN.
  - div_fix_en = 1 in FIX.
  - div_done = 1 in DONE.
  - div_zero_trap = div_done & zero_flag.
  - div_busy = 1 in every state except IDLE.
- Transitions (div_kill is checked after reset, before all other conditions):
  - IDLE: div_start -> CHK; capture div_thr, clear zero_flag.
  - CHK: divisor_zero=1 -> DONE with zero_flag set; otherwise -> RUN.
  - RUN: cntr == ITERS-1 -> FIX; otherwise stay in RUN.
  - FIX -> DONE, always.
  - DONE:
    - div_ack=0: stay in DONE.
    - div_ack=1 and div_start=0 -> IDLE.
    - div_ack=1 and div_start=1 -> CHK, with new thread captured and zero_flag cleared (back-to-back divide).
  - div_kill=1 in any state other than IDLE -> IDLE next edge. No div_done is produced; the thread tag is kept but is don't-care.
  - div_kill together with div_start in IDLE: the start is dropped.
- div_start outside IDLE, and outside DONE with ack, is ignored. There is no queueing.
- Counter alignment:
  - cnt_reset is high in CHK, so cntr reads 0 in the first RUN cycle.
  - cntr increments by 1 each RUN cycle, so RUN lasts exactly ITERS cycles.
  - ITERS=64 uses terminal 63; the counter never wraps inside RUN.
- Latency, with the start accepted at edge T (state CHK in cycle T+1):
  - Normal divide: RUN spans cycles T+2..T+1+ITERS, FIX is cycle T+2+ITERS, first div_done is cycle T+3+ITERS.
  - Zero divisor: div_done=1 with div_zero_trap=1 in cycle T+2; RUN and FIX are skipped.
- An ack in the first DONE cycle gives div_done exactly one cycle wide.

Test Plan:
- Reset/idle: hold rst_l=0 for 2 cycles, then release -> cnt_reset=1, busy/done/iter/fix=0, div_thr_out=0; idle 10 cycles with no state change.
- Normal divide, ITERS=32: start with thr=2, divisor_zero=0, ack 3 cycles after done rises.
  - iter_en high for exactly 32 cycles while cntr steps 0..31.
  - fix_en high for 1 cycle.
  - done high for 4 cycles with div_thr_out=2 and zero_trap=0; then IDLE.
- Divide-by-zero: start with thr=1, divisor_zero=1 in CHK -> done=1 and zero_trap=1 two cycles after start; iter_en and fix_en never assert; ack -> IDLE.
- Kill mid-RUN: kill when cntr=10 -> next cycle IDLE, cnt_reset=1, busy=0, done never asserts. A start 1 cycle later produces a full 32-iteration divide.
- Back-to-back: assert ack and start(thr=3) in the same DONE cycle -> CHK next cycle with div_thr_out=3, followed by a full divide. A second start issued during RUN is ignored.
- Reset mid-operation and boundary ITERS: rst_l=0 during FIX -> IDLE with done never asserted. Rebuild with ITERS=64 -> RUN lasts 64 cycles, FIX follows cntr=63, and no wrap to 0 is observed inside RUN.
